// File: rtl/adc_cnv_sequencer_if.sv
// adc_cnv_sequencer_if: config, handshake and BUSY/CNV signals between the sequencer and its neighbours
interface adc_cnv_sequencer_if #(
    parameter int NUM_CH    = 1,
    parameter int DIV_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic [DIV_WIDTH-1:0] cfg_divider;
    logic                 cfg_continuous;
    logic                 cfg_restart;
    logic                 cfg_zone1;
    logic [CNT_WIDTH-1:0] cfg_burst_len;
    logic                 ready;
    logic                 last;
    logic [NUM_CH-1:0]    busy;
    logic                 cnv;
    logic                 trigger_acq;
    logic                 running;
    logic [CNT_WIDTH-1:0] conv_count;
    logic                 err_overrun;

    modport master (
        output cfg_divider, cfg_continuous, cfg_restart, cfg_zone1, cfg_burst_len, ready, last, busy,
        input  cnv, trigger_acq, running, conv_count, err_overrun
    );

    modport slave (
        input  cfg_divider, cfg_continuous, cfg_restart, cfg_zone1, cfg_burst_len, ready, last, busy,
        output cnv, trigger_acq, running, conv_count, err_overrun
    );
endinterface

// File: rtl/adc_cnv_sequencer.sv
// adc_cnv_sequencer: programmable CNV generator with bursts, orderly stop and BUSY-edge acquisition triggers
module adc_cnv_sequencer #(
    parameter int NUM_CH    = 1,
    parameter int DIV_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter int CNV_HIGH  = 4
) (
    input logic                aclk,
    input logic                aresetn,
    adc_cnv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

    localparam int HW = $clog2(CNV_HIGH + 1);
    localparam logic [DIV_WIDTH-1:0] MIN_P = DIV_WIDTH'(CNV_HIGH + 2);

    state_t               state_q;
    logic [DIV_WIDTH-1:0] p_q, pc_q, p_d, pc_d;
    logic [HW-1:0]        hcnt_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 cnv_q, trig_q, run_q, err_q, busy_q, pend_q;
    logic                 busy_any, fall, rise, wrap, start, stop_req, go;

    always_comb begin
        busy_any = |bus.busy;
        fall     = busy_q & ~busy_any;
        rise     = ~busy_q & busy_any;
        p_d      = (bus.cfg_divider > MIN_P) ? bus.cfg_divider : MIN_P;
        wrap     = pc_q == p_q - DIV_WIDTH'(1);
        pc_d     = wrap ? '0 : pc_q + DIV_WIDTH'(1);
        // a pulse still in flight after a restart suppresses the first new period
        start    = state_q == RUN && pc_q == '0 && bus.ready && !cnv_q && !bus.cfg_restart;
        stop_req = bus.cfg_divider == '0 ||
                   (!bus.cfg_continuous && (bus.last || (bus.cfg_burst_len != '0 && cnt_q == bus.cfg_burst_len)));
        go       = bus.cfg_divider != '0 && (bus.cfg_restart || bus.cfg_continuous);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= STOP;
            p_q     <= MIN_P;
            pc_q    <= '0;
            hcnt_q  <= '0;
            cnt_q   <= '0;
            cnv_q   <= 1'b0;
            trig_q  <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            busy_q <= busy_any;
            trig_q <= bus.ready && (bus.cfg_zone1 ? fall : (rise && pend_q));
            pend_q <= bus.cfg_zone1 ? 1'b0 : rise ? 1'b0 : fall ? 1'b1 : pend_q;
            if (start) begin
                cnv_q  <= 1'b1;
                hcnt_q <= HW'(CNV_HIGH - 1);
                cnt_q  <= (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            end else if (cnv_q) begin
                if (hcnt_q == '0) cnv_q <= 1'b0;
                else hcnt_q <= hcnt_q - HW'(1);
            end
            if (bus.cfg_restart) err_q <= 1'b0;
            else if (start && busy_any) err_q <= 1'b1;
            case (state_q)
                STOP: begin
                    if (go) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                        pc_q    <= '0;
                        p_q     <= p_d;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (bus.cfg_restart) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                        pc_q    <= '0;
                        p_q     <= p_d;
                        cnt_q   <= '0;
                    end else begin
                        pc_q <= pc_d;
                        if (wrap) p_q <= p_d;
                        if (state_q == RUN && stop_req) state_q <= DRAIN;
                        else if (state_q == DRAIN && wrap) begin
                            state_q <= STOP;
                            run_q   <= 1'b0;
                            pend_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= STOP;
            endcase
        end
    end

    assign bus.cnv         = cnv_q;
    assign bus.trigger_acq = trig_q;
    assign bus.running     = run_q;
    assign bus.conv_count  = cnt_q;
    assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_adc_cnv_sequencer.sv
// tb_adc_cnv_sequencer: scoreboard bench; stimulus queues expected CNV/trigger events, a monitor pops and compares
module tb_adc_cnv_sequencer;
    localparam int NCH = 2, DW = 32, CW = 16, CH = 4;

    typedef struct {
        bit trg;
        int val;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    adc_cnv_sequencer_if #(.NUM_CH(NCH), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    adc_cnv_sequencer #(.NUM_CH(NCH), .DIV_WIDTH(DW), .CNT_WIDTH(CW), .CNV_HIGH(CH)) dut (
        .aclk(clk), .aresetn(aresetn), .bus(bus)
    );

    exp_t q[$];
    int total = 0, bad = 0, cyc = 0, last_rise = 0, hw = 0, age = 1000, f0 = 2, f1 = 5;
    bit auto_busy = 1'b0, cnv_p = 1'b0, cnv_b = 1'b0;
    logic [NCH-1:0] man_busy = '0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit trg, input int val, input int gap);
        q.push_back('{trg, val, gap});
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int k = 0;
        while (q.size() > n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (q.size() > n) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d pending events want %0d", name, q.size(), n);
            q.delete();
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (bus.running && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(bus.running), 0);
    endtask

    task automatic pulse_restart();
        bus.cfg_restart = 1'b1;
        @(negedge clk);
        bus.cfg_restart = 1'b0;
    endtask

    task automatic pulse_last();
        bus.last = 1'b1;
        @(negedge clk);
        bus.last = 1'b0;
    endtask

    // ADC model: BUSY per channel rises one cycle after CNV, ch0/ch1 stay high f0/f1 cycles
    initial begin
        bus.busy = '0;
        forever begin
            @(negedge clk);
            age   = (bus.cnv && !cnv_b) ? 0 : (age < 1000 ? age + 1 : age);
            cnv_b = bus.cnv;
            bus.busy = auto_busy ? {age >= 1 && age <= f1, age >= 1 && age <= f0} : man_busy;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.cnv && !cnv_p) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cnv_unexpected: got rise with count %0d want none", bus.conv_count);
                end else begin
                    e = q.pop_front();
                    chk("cnv_kind", int'(e.trg), 0);
                    chk("cnv_count", int'(bus.conv_count), e.val);
                    if (e.gap != 0) chk("cnv_gap", cyc - last_rise, e.gap);
                end
                last_rise = cyc;
            end
            if (!bus.cnv && cnv_p && aresetn) chk("cnv_width", hw, CH);
            hw = bus.cnv ? hw + 1 : 0;
            if (bus.trigger_acq) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL trg_unexpected: got trigger at age %0d want none", cyc - last_rise);
                end else begin
                    e = q.pop_front();
                    chk("trg_kind", int'(e.trg), 1);
                    chk("trg_age", cyc - last_rise, e.val);
                end
            end
            cnv_p = bus.cnv;
        end
    end

    initial begin
        bus.cfg_divider    = '0;
        bus.cfg_continuous = 1'b0;
        bus.cfg_restart    = 1'b0;
        bus.cfg_zone1      = 1'b1;
        bus.cfg_burst_len  = '0;
        bus.ready          = 1'b1;
        bus.last           = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cnv", int'(bus.cnv), 0);
        chk("rst_trg", int'(bus.trigger_acq), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_err", int'(bus.err_overrun), 0);
        chk("rst_count", int'(bus.conv_count), 0);
        aresetn = 1'b1;
        @(negedge clk);

        // continuous, period 10, Zone 1 with staggered BUSY falls (ch0 age 3, ch1 age 6)
        push(0, 1, 0); push(1, 7, 0); push(0, 2, 10); push(1, 7, 0); push(0, 3, 10); push(1, 7, 0);
        auto_busy = 1'b1; f0 = 2; f1 = 5;
        bus.cfg_divider = 10;
        bus.cfg_continuous = 1'b1;
        wait_q(0, 100, "t1_events");
        bus.cfg_divider = 0;
        wait_idle(40, "t1_running");
        chk("t1_count", int'(bus.conv_count), 3);

        // divider 3 clamps to 6
        auto_busy = 1'b0;
        bus.cfg_continuous = 1'b0;
        bus.cfg_divider = 3;
        push(0, 1, 0); push(0, 2, 6); push(0, 3, 6);
        pulse_restart();
        wait_q(0, 100, "t2_events");
        pulse_last();
        wait_idle(40, "t2_running");
        chk("t2_count", int'(bus.conv_count), 3);
        chk("t2_err", int'(bus.err_overrun), 0);

        // burst of 5 in Zone 2: trigger at the BUSY rise of the following conversion
        bus.cfg_zone1 = 1'b0;
        bus.cfg_divider = 10;
        bus.cfg_burst_len = 5;
        auto_busy = 1'b1; f0 = 3; f1 = 3;
        push(0, 1, 0);
        for (int i = 2; i <= 5; i++) begin
            push(0, i, 10);
            push(1, 2, 0);
        end
        pulse_restart();
        wait_q(0, 150, "t3_events");
        wait_idle(40, "t3_running");
        chk("t3_count", int'(bus.conv_count), 5);
        repeat (12) @(negedge clk);
        chk("t3_count_hold", int'(bus.conv_count), 5);
        auto_busy = 1'b0;
        man_busy = 2'b01;
        repeat (4) @(negedge clk);
        man_busy = 2'b00;
        repeat (4) @(negedge clk);
        bus.cfg_burst_len = 0;

        // ready low at the second pc=0 skips that period
        push(0, 1, 0); push(0, 2, 20); push(0, 3, 10);
        pulse_restart();
        wait_q(2, 50, "t4_first");
        repeat (9) @(negedge clk);
        bus.ready = 1'b0;
        @(negedge clk);
        bus.ready = 1'b1;
        wait_q(0, 100, "t4_events");
        pulse_last();
        wait_idle(40, "t4_running");

        // BUSY held across pc=0 raises a sticky overrun
        man_busy = 2'b10;
        repeat (2) @(negedge clk);
        push(0, 1, 0); push(0, 2, 10);
        pulse_restart();
        wait_q(1, 50, "t5_first");
        chk("ovr_set", int'(bus.err_overrun), 1);
        man_busy = 2'b00;
        wait_q(0, 50, "t5_events");
        chk("ovr_sticky", int'(bus.err_overrun), 1);
        repeat (5) @(negedge clk);
        push(0, 1, 0);
        pulse_restart();
        chk("ovr_clr", int'(bus.err_overrun), 0);
        chk("restart_count", int'(bus.conv_count), 0);
        wait_q(0, 50, "t5_rerun");

        // last and restart together: stays running, count cleared
        push(0, 1, 0);
        repeat (2) @(negedge clk);
        bus.cfg_restart = 1'b1;
        bus.last = 1'b1;
        @(negedge clk);
        bus.cfg_restart = 1'b0;
        bus.last = 1'b0;
        chk("t6_running", int'(bus.running), 1);
        chk("t6_count", int'(bus.conv_count), 0);
        wait_q(0, 50, "t6_events");

        // reset in the middle of a CNV pulse
        @(negedge clk);
        chk("t7_cnv_before", int'(bus.cnv), 1);
        aresetn = 1'b0;
        @(negedge clk);
        chk("t7_cnv", int'(bus.cnv), 0);
        chk("t7_trg", int'(bus.trigger_acq), 0);
        chk("t7_running", int'(bus.running), 0);
        chk("t7_err", int'(bus.err_overrun), 0);
        chk("t7_count", int'(bus.conv_count), 0);
        aresetn = 1'b1;
        repeat (15) @(negedge clk);
        chk("q_empty", q.size(), 0);
        chk("t7_stopped", int'(bus.running), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
